// File: rtl/mem_stage_dcache_pkg.sv
// mem_stage_dcache_pkg: shared widths and FSM state encoding for the MEM-stage data cache
package mem_stage_dcache_pkg;
  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int INDEX_W_DEF = 4;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/mem_stage_dcache_array.sv
// mem_stage_dcache_array: valid/tag/data storage, async read, sync write, valid clear on invalidate or reset
//   clr_i clears every valid bit; a same-cycle we_i sets its own line afterwards.
//   ridx_i selects the line shown on valid_o/tag_o/data_o.
module dcache_array
  import mem_stage_dcache_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int TAG_W   = ADDR_W_DEF - INDEX_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] widx_i,
  input  logic [TAG_W-1:0]   wtag_i,
  input  logic [DATA_W-1:0]  wdata_i,
  input  logic [INDEX_W-1:0] ridx_i,
  output logic               valid_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic [DATA_W-1:0]  data_o
);
  localparam int LINES = 1 << INDEX_W;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (clr_i) valid_q <= '0;
      if (we_i) valid_q[widx_i] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wdata_i;
    end
  end
  assign valid_o = valid_q[ridx_i];
  assign tag_o   = tag_q[ridx_i];
  assign data_o  = data_q[ridx_i];
endmodule

// File: rtl/mem_stage_dcache.sv
// mem_stage_dcache: direct-mapped write-through/write-allocate data cache for the MEM stage
//   Pipeline side: MemRead/MemWrite/address/write_data/invalidate_all in, memory_read_data/hit out (hit=0 stalls).
//   Memory side: mem_req/mem_we/mem_addr/mem_wdata out, held until the one-cycle mem_ack with mem_rdata.
module mem_stage_dcache
  import mem_stage_dcache_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              invalidate_all,
  output logic [DATA_W-1:0] memory_read_data,
  output logic              hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  localparam int TAG_W = ADDR_W - INDEX_W;
  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, fill_q, fill_d;
  logic              arr_we, arr_valid, rd_hit, access, ack;
  logic [TAG_W-1:0]  arr_tag;
  logic [DATA_W-1:0] arr_data;
  dcache_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (invalidate_all && state_q == IDLE),
    .we_i    (arr_we),
    .widx_i  (mem_addr_q[INDEX_W-1:0]),
    .wtag_i  (mem_addr_q[ADDR_W-1:INDEX_W]),
    .wdata_i (state_q == FILL ? mem_rdata : mem_wdata_q),
    .ridx_i  (address[INDEX_W-1:0]),
    .valid_o (arr_valid),
    .tag_o   (arr_tag),
    .data_o  (arr_data)
  );
  assign access = MemRead || MemWrite;
  assign rd_hit = MemRead && !MemWrite && arr_valid && arr_tag == address[ADDR_W-1:INDEX_W];
  assign ack    = mem_ack && mem_req_q;
  always_comb begin
    state_d          = state_q;
    mem_req_d        = mem_req_q;
    mem_we_d         = mem_we_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    fill_d           = fill_q;
    arr_we           = 1'b0;
    hit              = 1'b0;
    memory_read_data = '0;
    case (state_q)
      IDLE: begin
        hit              = !access || rd_hit;
        memory_read_data = rd_hit ? arr_data : '0;
        if (access && !rd_hit) begin
          state_d     = MemWrite ? WRITE : FILL;
          mem_req_d   = 1'b1;
          mem_we_d    = MemWrite;
          mem_addr_d  = address;
          mem_wdata_d = MemWrite ? write_data : mem_wdata_q;
        end
      end
      FILL, WRITE: begin
        if (ack) begin
          arr_we    = 1'b1;
          mem_req_d = 1'b0;
          state_d   = DONE;
          fill_d    = state_q == FILL ? mem_rdata : fill_q;
        end
      end
      DONE: begin
        hit              = 1'b1;
        memory_read_data = mem_we_q ? '0 : fill_q;
        state_d          = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fill_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      fill_q      <= fill_d;
    end
  end
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_stage_dcache.sv
// tb_mem_stage_dcache: scoreboard bench for mem_stage_dcache against a behavioural cache/memory model
module tb_mem_stage_dcache;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, invalidate_all = 1'b0, mem_ack = 1'b0;
  logic [15:0] address = '0, write_data = '0, mem_rdata = '0;
  logic [15:0] memory_read_data, mem_addr, mem_wdata;
  logic        hit, mem_req, mem_we;
  always #5 clk = ~clk;
  mem_stage_dcache dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite), .address(address),
    .write_data(write_data), .invalidate_all(invalidate_all), .memory_read_data(memory_read_data),
    .hit(hit), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );
  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask
  logic [15:0] ext_mem [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];
  function automatic logic [15:0] dflt(input logic [15:0] a);
    logic [15:0] m;
    m = a * 16'h9E37;
    return m ^ 16'h5A5A;
  endfunction
  function automatic logic [15:0] ext_rd(input logic [15:0] a);
    return ext_mem.exists(a) ? ext_mem[a] : dflt(a);
  endfunction
  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction
  // main memory: ack once the request has been held for cur_lat full cycles
  int cur_lat = 2;
  bit late_ack = 0;
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (late_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'($urandom);
        late_ack  = 0;
        cnt       = 0;
      end else if (mem_req) begin
        cnt++;
        if (cnt == cur_lat + 1) begin
          mem_ack = 1'b1;
          if (mem_we) ext_mem[mem_addr] = mem_wdata;
          else mem_rdata = ext_rd(mem_addr);
        end
      end else cnt = 0;
    end
  end
  // reference cache: which lines are present, keyed by index
  bit          cv [16];
  logic [11:0] ct [16];
  typedef struct {
    logic [15:0] data;
    int          low;
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    bit          miss;
  } exp_t;
  exp_t sbq[$];
  task automatic clear_model();
    for (int k = 0; k < 16; k++) cv[k] = 0;
  endtask
  task automatic access(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                        input int lat, input bit inv);
    exp_t e;
    logic [3:0] i;
    bit h;
    int n;
    i = a[3:0];
    h = rd && !wr && cv[i] && ct[i] == a[15:4];
    e.miss  = !h;
    e.we    = wr;
    e.addr  = a;
    e.wdata = d;
    e.low   = h ? 0 : lat + 2;
    e.data  = wr ? 16'h0 : ref_rd(a);
    if (inv) clear_model();
    if (wr) ref_mem[a] = d;
    if (!h) begin
      cv[i] = 1;
      ct[i] = a[15:4];
    end
    sbq.push_back(e);
    cur_lat = lat;
    @(posedge clk);
    #1;
    MemRead = rd; MemWrite = wr; address = a; write_data = d; invalidate_all = inv;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!hit && n < 200);
    if (!hit) begin
      chk("timeout_hit", {31'b0, hit}, 1);
      sbq.delete();
    end
    @(posedge clk);
    #1;
    MemRead = 0; MemWrite = 0; invalidate_all = 0;
  endtask
  task automatic inval();
    @(posedge clk);
    #1 invalidate_all = 1;
    @(posedge clk);
    #1 invalidate_all = 0;
    clear_model();
  endtask
  // monitor: every negedge, compare whatever the DUT presents against the scoreboard
  initial begin
    int low = 0;
    bit seen = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        low = 0; seen = 0;
      end else if (!(MemRead || MemWrite)) begin
        chk("idle_hit", {31'b0, hit}, 1);
        chk("idle_data", {16'b0, memory_read_data}, 0);
      end else if (!hit) begin
        low++;
        if (mem_req && !seen && sbq.size() > 0) begin
          seen = 1;
          e = sbq[0];
          chk("mem_addr", {16'b0, mem_addr}, {16'b0, e.addr});
          chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
          if (e.we) chk("mem_wdata", {16'b0, mem_wdata}, {16'b0, e.wdata});
        end
      end else if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_hit act=%0h exp=none", memory_read_data);
      end else begin
        e = sbq.pop_front();
        chk("rd_data", {16'b0, memory_read_data}, {16'b0, e.data});
        chk("stall_cycles", low, e.low);
        chk("miss_req", {31'b0, seen}, {31'b0, e.miss});
        low = 0; seen = 0;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end
  initial begin
    logic [11:0] tags [4];
    int k;
    tags = '{12'h000, 12'h001, 12'h002, 12'hFFF};
    #12;
    chk("rst_hit", {31'b0, hit}, 1);
    chk("rst_data", {16'b0, memory_read_data}, 0);
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 0);
    chk("rst_mem_wdata", {16'b0, mem_wdata}, 0);
    @(posedge clk);
    #1 rst_n = 1;
    ext_mem[16'h0013] = 16'hBEEF;
    ref_mem[16'h0013] = 16'hBEEF;
    access(1, 0, 16'h0013, 0, 3, 0);
    access(1, 0, 16'h0013, 0, 3, 0);
    access(1, 0, 16'h0023, 0, 2, 0);
    access(1, 0, 16'h0013, 0, 1, 0);
    access(0, 1, 16'h0040, 16'h1234, 2, 0);
    access(1, 0, 16'h0040, 0, 2, 0);
    inval();
    access(1, 0, 16'h0040, 0, 0, 0);
    access(1, 0, 16'h0055, 0, 3, 1);
    access(1, 0, 16'h0055, 0, 3, 0);
    inval();
    cur_lat = 50;
    @(posedge clk);
    #1 MemRead = 1; address = 16'h0777;
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("abort_mem_req", {31'b0, mem_req}, 0);
    chk("abort_mem_addr", {16'b0, mem_addr}, 0);
    MemRead = 0;
    clear_model();
    @(posedge clk);
    #1 rst_n = 1; late_ack = 1; cur_lat = 2;
    repeat (3) @(posedge clk);
    access(1, 0, 16'h0777, 0, 2, 0);
    access(1, 1, 16'h0005, 16'h00AA, 1, 0);
    access(1, 0, 16'h0005, 0, 1, 0);
    repeat (250) begin
      k = $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0, 1: access(1, 0, {tags[$urandom_range(0, 3)], 4'($urandom)}, 0, $urandom_range(0, 4), k == 0);
        2: access(0, 1, {tags[$urandom_range(0, 3)], 4'($urandom)}, 16'($urandom), $urandom_range(0, 4), k == 0);
        default: access(1, 1, {tags[$urandom_range(0, 3)], 4'($urandom)}, 16'($urandom), $urandom_range(0, 4), k == 0);
      endcase
      if (k == 1) inval();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (5) @(posedge clk);
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL pending_expect act=%0d exp=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
